bram_frame_reader: RTL and testbench



---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_timing.sv | 64 ++++++
 rtl/bram_frame_reader.sv | 106 ++++++++++
 tb/tb_bram_frame_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and the
// sync bundle carried down the output alignment pipeline.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_ADDR_W = 17;
  localparam int PIX_W     = 12;
  localparam int CNT_W     = 10;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [PIX_W-1:0]     pix_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic first;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{
    hsync: 1'b1,
    vsync: 1'b1,
    blank: 1'b1,
    first: 1'b0
  };

  // (v>>1)*320 + (h>>1) as shift-adds: 320 = 256 + 64
  function automatic fb_addr_t fb_addr(
    input cnt_t h,
    input cnt_t v
  );
    fb_addr_t x;
    fb_addr_t y;
    x = fb_addr_t'(h[CNT_W-1:1]);
    y = fb_addr_t'(v[CNT_W-1:1]);
    return (y << 8) + (y << 6) + x;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters with raw syncs and blank; also exposes the
// next raster position so consumers can pre-register from it.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT  = H_ACTIVE,
  parameter int H_FPW  = H_FP,
  parameter int H_SYW  = H_SYNC,
  parameter int H_BPW  = H_BP,
  parameter int V_ACT  = V_ACTIVE,
  parameter int V_FPW  = V_FP,
  parameter int V_SYW  = V_SYNC,
  parameter int V_BPW  = V_BP
) (
  input  logic clk,
  input  logic reset,
  output cnt_t hcount,
  output cnt_t vcount,
  output cnt_t h_next,
  output cnt_t v_next,
  output logic next_active,
  output logic hsync,
  output logic vsync,
  output logic blank
);

  localparam int HT = H_ACT + H_FPW + H_SYW + H_BPW;
  localparam int VT = V_ACT + V_FPW + V_SYW + V_BPW;

  localparam cnt_t H_LAST = CNT_W'(HT - 1);
  localparam cnt_t V_LAST = CNT_W'(VT - 1);
  localparam cnt_t H_VIS  = CNT_W'(H_ACT);
  localparam cnt_t V_VIS  = CNT_W'(V_ACT);
  localparam cnt_t HS_BEG = CNT_W'(H_ACT + H_FPW);
  localparam cnt_t HS_END = CNT_W'(H_ACT + H_FPW + H_SYW);
  localparam cnt_t VS_BEG = CNT_W'(V_ACT + V_FPW);
  localparam cnt_t VS_END = CNT_W'(V_ACT + V_FPW + V_SYW);

  always_comb begin
    h_next = hcount + CNT_W'(1);
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
    end
  end

  assign next_active = (h_next < H_VIS) && (v_next < V_VIS);

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_next;
      vcount <= v_next;
    end
  end

  assign hsync = !((hcount >= HS_BEG) && (hcount < HS_END));
  assign vsync = !((vcount >= VS_BEG) && (vcount < VS_END));
  assign blank = !((hcount < H_VIS) && (vcount < V_VIS));

endmodule

// File: rtl/bram_frame_reader.sv
// 320x240 frame-buffer scan-out to 640x480@60 VGA with 2x pixel
// doubling; syncs delayed to line up with BRAM read data.
module bram_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [FB_ADDR_W-1:0] bram_addr,
  input  logic [PIX_W-1:0]     bram_data,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_blank,
  output logic                 frame_start
);

  localparam int PIPE = RD_LATENCY + 1;

  cnt_t  hcount;
  cnt_t  vcount;
  cnt_t  h_next;
  cnt_t  v_next;
  logic  next_active;
  logic  t_hsync;
  logic  t_vsync;
  logic  t_blank;
  sync_t raw;
  sync_t pipe_q [PIPE];
  pix_t  rgb_q;

  vga_timing #(
    .H_ACT (H_ACTIVE),
    .H_FPW (H_FP),
    .H_SYW (H_SYNC),
    .H_BPW (H_BP),
    .V_ACT (V_ACTIVE),
    .V_FPW (V_FP),
    .V_SYW (V_SYNC),
    .V_BPW (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .h_next      (h_next),
    .v_next      (v_next),
    .next_active (next_active),
    .hsync       (t_hsync),
    .vsync       (t_vsync),
    .blank       (t_blank)
  );

  always_comb begin
    raw       = SYNC_IDLE;
    raw.hsync = t_hsync;
    raw.vsync = t_vsync;
    raw.blank = t_blank;
    raw.first = (hcount == '0) && (vcount == '0);
  end

  // Address is taken from the next raster position, so the register
  // holds the address for whatever the counters currently hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_addr <= '0;
    end else if (next_active) begin
      bram_addr <= fb_addr(h_next, v_next);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) begin
        pipe_q[i] <= SYNC_IDLE;
      end
      rgb_q <= '0;
    end else begin
      pipe_q[0] <= raw;
      for (int i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      rgb_q <= pipe_q[PIPE-2].blank ? '0 : bram_data;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hsync   = pipe_q[PIPE-1].hsync;
  assign vga_vsync   = pipe_q[PIPE-1].vsync;
  assign vga_blank   = pipe_q[PIPE-1].blank;
  assign frame_start = pipe_q[PIPE-1].first;

endmodule

// File: tb/tb_bram_frame_reader.sv
// Directed bench: three latency builds at full 640x480 timing plus a
// shrunken-timing build for frame-rate sync periods.
module tb_bram_frame_reader;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic force_fff = 1'b0;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [16:0] a1, a2, a3, as_;
  logic [11:0] d1, d2, d3;
  logic [11:0] rgb1, rgb2, rgb3, rgbs;
  logic hs1, hs2, hs3, hss;
  logic vs1, vs2, vs3, vss;
  logic bl1, bl2, bl3, bls;
  logic fs1, fs2, fs3, fss;

  logic [11:0] m1 [1];
  logic [11:0] m2 [2];
  logic [11:0] m3 [3];

  // BRAM models returning addr[11:0] after 1, 2 and 3 clocks
  always @(posedge clk) begin
    m1[0] <= a1[11:0];
    m2[0] <= a2[11:0];
    m2[1] <= m2[0];
    m3[0] <= a3[11:0];
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end

  assign d1 = force_fff ? 12'hFFF : m1[0];
  assign d2 = force_fff ? 12'hFFF : m2[1];
  assign d3 = force_fff ? 12'hFFF : m3[2];

  bram_frame_reader #(.RD_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .bram_addr(a1), .bram_data(d1),
    .vga_r(rgb1[11:8]), .vga_g(rgb1[7:4]), .vga_b(rgb1[3:0]),
    .vga_hsync(hs1), .vga_vsync(vs1), .vga_blank(bl1),
    .frame_start(fs1)
  );

  bram_frame_reader #(.RD_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .bram_addr(a2), .bram_data(d2),
    .vga_r(rgb2[11:8]), .vga_g(rgb2[7:4]), .vga_b(rgb2[3:0]),
    .vga_hsync(hs2), .vga_vsync(vs2), .vga_blank(bl2),
    .frame_start(fs2)
  );

  bram_frame_reader #(.RD_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .bram_addr(a3), .bram_data(d3),
    .vga_r(rgb3[11:8]), .vga_g(rgb3[7:4]), .vga_b(rgb3[3:0]),
    .vga_hsync(hs3), .vga_vsync(vs3), .vga_blank(bl3),
    .frame_start(fs3)
  );

  // 24 x 12 raster: hsync low 4 clk, vsync low 2 lines, frame 288 clk
  bram_frame_reader #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RD_LATENCY(2)
  ) us (
    .clk(clk), .reset(reset), .bram_addr(as_), .bram_data(12'h000),
    .vga_r(rgbs[11:8]), .vga_g(rgbs[7:4]), .vga_b(rgbs[3:0]),
    .vga_hsync(hss), .vga_vsync(vss), .vga_blank(bls),
    .frame_start(fss)
  );

  function automatic bit bad_out(
    input int k, input int pipe, input bit fff,
    input logic [11:0] rgb,
    input logic hs, input logic vs,
    input logic bl, input logic fs
  );
    int p, h, v;
    bit vis;
    logic [11:0] er;
    logic ehs, evs, ebl, efs;
    er = 12'h000; ehs = 1'b1; evs = 1'b1; ebl = 1'b1; efs = 1'b0;
    if (k >= pipe) begin
      p = k - pipe;
      h = p % 800;
      v = (p / 800) % 525;
      vis = (h < 640) && (v < 480);
      if (vis) er = fff ? 12'hFFF : 12'(((v / 2) * 320 + h / 2));
      ehs = !(h >= 656 && h < 752);
      evs = !(v >= 490 && v < 492);
      ebl = !vis;
      efs = (h == 0 && v == 0);
    end
    return (rgb !== er) || (hs !== ehs) || (vs !== evs) ||
           (bl !== ebl) || (fs !== efs);
  endfunction

  localparam int N_SCAN = 12 * 800 + 8;

  logic [16:0] la [640];
  logic [16:0] lb [640];

  initial begin
    int e1, e2, e3, ea, eaddr, nb, md, ef;
    int hf0, hf1, hr0, ff1, ff2, ff3;
    int vf0, vf1, vr0, sh0, sh1, sf0, sf1;
    logic hs2p, vssp, hssp, fssp;
    e1 = 0; e2 = 0; e3 = 0; ea = 0; eaddr = 0; nb = 0; md = 0; ef = 0;
    hf0 = -1; hf1 = -1; hr0 = -1; ff1 = -1; ff2 = -1; ff3 = -1;
    vf0 = -1; vf1 = -1; vr0 = -1; sh0 = -1; sh1 = -1; sf0 = -1; sf1 = -1;
    hs2p = 1'b1; vssp = 1'b1; hssp = 1'b1; fssp = 1'b0;

    chk("fb_addr_max", int'(fb_addr(10'd639, 10'd479)), 76799);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);

    // mid-line reset held for 5 clocks
    reset = 1'b1;
    @(negedge clk);
    chk("rst_hcount", int'(u2.u_timing.hcount), 0);
    repeat (4) @(negedge clk);
    chk("rst_rgb", int'(rgb2), 0);
    chk("rst_sync", int'({hs2, vs2, bl2, fs2}), 4'b1110);
    chk("rst_addr", int'(a2), 0);
    chk("rst_vcount", int'(u2.u_timing.vcount), 0);
    reset = 1'b0;

    for (int k = 0; k < N_SCAN; k++) begin
      int h, v;
      if (k > 0) @(negedge clk);
      if (bad_out(k, 2, 1'b0, rgb1, hs1, vs1, bl1, fs1)) e1++;
      if (bad_out(k, 3, 1'b0, rgb2, hs2, vs2, bl2, fs2)) e2++;
      if (bad_out(k, 4, 1'b0, rgb3, hs3, vs3, bl3, fs3)) e3++;
      h = k % 800;
      v = k / 800;
      if (h < 640 && v < 480) eaddr = (v / 2) * 320 + h / 2;
      if (a1 !== 17'(eaddr) || a2 !== 17'(eaddr) || a3 !== 17'(eaddr)) ea++;
      if (k == 0) chk("rel_hcount", int'(u2.u_timing.hcount), 0);
      if (k == 0) chk("addr_h0_v0", int'(a2), 0);
      if (k == 2) chk("addr_h2_v0", int'(a2), 1);
      if (k == 801) chk("addr_h1_v1", int'(a2), 0);
      if (k == 5) chk("rgb_h2_v0", int'(rgb2), 12'h001);
      if (k < 3 && bl2 === 1'b1) nb++;
      if (v == 10 && h < 640) la[h] = a2;
      if (v == 11 && h < 640) lb[h] = a2;
      if (k > 0 && hs2p && !hs2) begin
        if (hf0 < 0) hf0 = k;
        else if (hf1 < 0) hf1 = k;
      end
      if (k > 0 && !hs2p && hs2 && hf0 >= 0 && hr0 < 0) hr0 = k;
      if (fs1 === 1'b1 && ff1 < 0) ff1 = k;
      if (fs2 === 1'b1 && ff2 < 0) ff2 = k;
      if (fs3 === 1'b1 && ff3 < 0) ff3 = k;
      if (k > 0 && vssp && !vss) begin
        if (vf0 < 0) vf0 = k;
        else if (vf1 < 0) vf1 = k;
      end
      if (k > 0 && !vssp && vss && vf0 >= 0 && vr0 < 0) vr0 = k;
      if (k > 0 && hssp && !hss) begin
        if (sh0 < 0) sh0 = k;
        else if (sh1 < 0) sh1 = k;
      end
      if (!fssp && fss) begin
        if (sf0 < 0) sf0 = k;
        else if (sf1 < 0) sf1 = k;
      end
      hs2p = hs2; vssp = vss; hssp = hss; fssp = fss;
    end

    chk("img_lat1", e1, 0);
    chk("img_lat2", e2, 0);
    chk("img_lat3", e3, 0);
    chk("addr_seq", ea, 0);
    chk("blank_after_rst", nb, 3);
    chk("fs_first_lat1", ff1, 2);
    chk("fs_first_lat2", ff2, 3);
    chk("fs_first_lat3", ff3, 4);
    chk("hsync_first_fall", hf0, 659);
    chk("hsync_period", hf1 - hf0, 800);
    chk("hsync_low", hr0 - hf0, 96);
    for (int i = 0; i < 640; i++) if (la[i] !== lb[i]) md++;
    chk("line_dbl", md, 0);
    chk("line10_start", int'(la[0]), 1600);
    chk("line10_end", int'(la[639]), 1919);
    chk("s_hsync_period", sh1 - sh0, 24);
    chk("s_vsync_period", vf1 - vf0, 288);
    chk("s_vsync_low", vr0 - vf0, 48);
    chk("s_fs_period", sf1 - sf0, 288);

    // blanked region must stay black even with all-ones read data
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    force_fff = 1'b1;
    for (int k = 0; k < 1700; k++) begin
      if (k > 0) @(negedge clk);
      if (bad_out(k, 3, 1'b1, rgb2, hs2, vs2, bl2, fs2)) ef++;
    end
    chk("blank_fff", ef, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
